// File: rtl/ecg_pkg.sv
// ---------------------------------------------------------------------------
// ecg_pkg
// Shared definitions for the ECG ADC sampling front end.
//   ECG_DATA_WIDTH  : default width of the signed sample handed to the filters
//   DISCARD_PERIODS : SCLK periods at the start of each frame that carry no
//                     data (two sample-and-hold periods plus the null bit)
//   conv_state_e    : states of the SPI conversion sequencer
//   conv_latency()  : cycles from a sample tick to its en_out strobe
// ---------------------------------------------------------------------------
package ecg_pkg;

  localparam int unsigned ECG_DATA_WIDTH  = 16;
  localparam int unsigned DISCARD_PERIODS = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_DONE
  } conv_state_e;

  // CS setup, the full serial frame, CS hold, then the DONE cycle itself.
  function automatic int unsigned conv_latency(input int unsigned clk_div,
                                               input int unsigned adc_bits);
    return 2 * clk_div * (adc_bits + DISCARD_PERIODS) + 2 * clk_div + 1;
  endfunction

endpackage

// File: rtl/ecg_adc_sampler_tick_gen.sv
// ---------------------------------------------------------------------------
// sample_tick_gen
// Free-running sample-rate timer. Counts 0..SAMPLE_PERIOD-1 while enabled
// and pulses tick for one cycle in the cycle it wraps back to zero.
//   clk    : block clock, rising edge
//   rst    : synchronous active-high reset
//   enable : level; when low the counter is held at zero
//   tick   : one-cycle pulse requesting a new conversion
// ---------------------------------------------------------------------------
module sample_tick_gen #(
  parameter int unsigned SAMPLE_PERIOD = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             at_wrap;

  assign at_wrap = (count_q == CNT_W'(SAMPLE_PERIOD - 1));
  assign tick    = enable && at_wrap;

  // Holding the count at zero while disabled means the first tick after
  // enable rises comes a full SAMPLE_PERIOD later.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (!enable || at_wrap) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ecg_adc_sampler.sv
// ---------------------------------------------------------------------------
// ecg_adc_sampler
// Periodically reads one sample from an offset-binary serial ADC over an
// SPI-style link and presents it as a signed sample with a one-cycle strobe.
//   clk      : block clock, rising edge
//   rst      : synchronous active-high reset
//   enable   : level; high permits new conversions to start
//   adc_miso : serial data from the ADC
//   adc_csn  : ADC chip select, active low
//   adc_sclk : ADC serial clock, idle low
//   xout     : signed sample for the filter chain
//   en_out   : one-cycle strobe advancing the filter chain
//   overrun  : sticky; a tick arrived while a conversion was busy
// ---------------------------------------------------------------------------
module ecg_adc_sampler
  import ecg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = ECG_DATA_WIDTH,
  parameter int unsigned ADC_BITS      = 12,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 250000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         adc_miso,
  output logic                         adc_csn,
  output logic                         adc_sclk,
  output logic signed [DATA_WIDTH-1:0] xout,
  output logic                         en_out,
  output logic                         overrun
);

  localparam int unsigned FRAME_PERIODS = ADC_BITS + DISCARD_PERIODS;
  localparam int unsigned DIV_W         = $clog2(2 * CLK_DIV);
  localparam int unsigned PER_W         = $clog2(FRAME_PERIODS + 1);

  conv_state_e                  state_q, state_d;
  logic        [DIV_W-1:0]      div_q, div_d;
  logic        [PER_W-1:0]      period_q, period_d;
  logic        [ADC_BITS-1:0]   shift_q, shift_d;
  logic signed [DATA_WIDTH-1:0] xout_q, xout_d;
  logic                         overrun_q, overrun_d;
  logic                         tick;
  logic                         sclk_rise;
  logic signed [ADC_BITS-1:0]   code_signed;

  sample_tick_gen #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

  // Within a SHIFT period div_q runs 0..2*CLK_DIV-1; the upper half is the
  // SCLK-high phase, so the cycle where div_q first reaches CLK_DIV is the
  // rising edge at which the ADC bit is taken.
  assign sclk_rise = (state_q == ST_SHIFT) && (div_q == DIV_W'(CLK_DIV));

  // Offset binary to two's complement is just an MSB flip.
  assign code_signed = {~shift_q[ADC_BITS-1], shift_q[ADC_BITS-2:0]};

  // Conversion sequencer. div_q is shared as the CS setup/hold timer and
  // the SCLK phase counter, since only one of them is ever active.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    period_d  = period_q;
    shift_d   = shift_q;
    xout_d    = xout_q;
    overrun_d = overrun_q | (tick && (state_q != ST_IDLE));

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d  = ST_CS_SETUP;
          div_d    = '0;
          period_d = '0;
          shift_d  = '0;
        end
      end
      ST_CS_SETUP: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          state_d = ST_SHIFT;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_SHIFT: begin
        // The first periods carry sample/null bits and are not kept.
        if (sclk_rise && (period_q >= PER_W'(DISCARD_PERIODS))) begin
          shift_d = {shift_q[ADC_BITS-2:0], adc_miso};
        end
        if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
          div_d = '0;
          if (period_q == PER_W'(FRAME_PERIODS - 1)) begin
            state_d  = ST_CS_HOLD;
            period_d = '0;
          end else begin
            period_d = period_q + PER_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_CS_HOLD: begin
        // Load the sample on entry to DONE so it is valid with the strobe.
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          state_d = ST_DONE;
          div_d   = '0;
          xout_d  = DATA_WIDTH'(code_signed);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      period_q  <= '0;
      shift_q   <= '0;
      xout_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      period_q  <= period_d;
      shift_q   <= shift_d;
      xout_q    <= xout_d;
      overrun_q <= overrun_d;
    end
  end

  assign adc_csn  = !((state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) ||
                      (state_q == ST_CS_HOLD));
  assign adc_sclk = (state_q == ST_SHIFT) && (div_q >= DIV_W'(CLK_DIV));
  assign en_out   = (state_q == ST_DONE);
  assign xout     = xout_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_ecg_adc_sampler.sv
// ---------------------------------------------------------------------------
// tb_ecg_adc_sampler
// Scoreboard bench for ecg_adc_sampler. A reference model follows the
// sampling rules at the cycle level (ticks, busy window, overrun) and
// queues the expected sample and strobe cycle for each accepted tick; an
// ADC model serves the requested codes over the serial link; a monitor
// compares every cycle against the queued expectations.
// ---------------------------------------------------------------------------
module tb_ecg_adc_sampler;

  localparam int DATA_WIDTH    = 16;
  localparam int ADC_BITS      = 12;
  localparam int CLK_DIV       = 4;
  localparam int SAMPLE_PERIOD = 100;
  localparam int FRAME_RISES   = ADC_BITS + 3;
  localparam int LATENCY       = 2 * CLK_DIV * (ADC_BITS + 3) + 2 * CLK_DIV + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] xout;
    int                    cyc;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic                  enable;
  logic                  adc_miso;
  logic                  adc_csn;
  logic                  adc_sclk;
  logic [DATA_WIDTH-1:0] xout;
  logic                  en_out;
  logic                  overrun;

  int vectors     = 0;
  int miscompares = 0;

  exp_t                expQ[$];
  logic [ADC_BITS-1:0] codeQ[$];
  logic [ADC_BITS-1:0] directedQ[$];

  int cyc         = 0;
  int runLen      = 0;
  int busyEnd     = 0;
  bit mOvr        = 1'b0;
  int sclkRises   = 0;
  int csnFalls    = 0;
  int strobeCount = 0;

  ecg_adc_sampler #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADC_BITS     (ADC_BITS),
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .adc_miso(adc_miso),
    .adc_csn (adc_csn),
    .adc_sclk(adc_sclk),
    .xout    (xout),
    .en_out  (en_out),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Drive the control inputs just after a falling edge and hold them.
  task automatic applyStimulus(input logic r, input logic e, input int cycles);
    rst    = r;
    enable = e;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model: a tick lands on every SAMPLE_PERIOD-th consecutive
  // enabled cycle. A tick is accepted only once the previous conversion
  // has fully returned to idle; otherwise it only raises overrun.
  always @(posedge clk) begin
    logic [ADC_BITS-1:0] code;
    cyc++;
    if (rst) begin
      runLen  = 0;
      busyEnd = 0;
      mOvr    = 1'b0;
      expQ.delete();
      codeQ.delete();
    end else if (!enable) begin
      runLen = 0;
    end else begin
      runLen++;
      if (runLen % SAMPLE_PERIOD == 0) begin
        if (cyc >= busyEnd) begin
          if (directedQ.size() > 0) code = directedQ.pop_front();
          else                      code = ADC_BITS'($urandom);
          codeQ.push_back(code);
          expQ.push_back('{xout: DATA_WIDTH'(int'(code) - (1 << (ADC_BITS - 1))),
                           cyc: cyc + LATENCY - 1});
          busyEnd = cyc + LATENCY + 1;
        end else begin
          mOvr = 1'b1;
        end
      end
    end
  end

  always @(posedge adc_sclk) sclkRises++;
  always @(negedge adc_csn)  csnFalls++;

  // ADC model: on chip select, take the next requested code and present
  // junk for the three leading periods, then the code MSB first, changing
  // data on the SCLK falling edge.
  initial begin
    logic [ADC_BITS-1:0] code;
    int                  rises;
    adc_miso = 1'b0;
    forever begin
      @(negedge adc_csn);
      checkOutput("adc_frame_requested", 32'(codeQ.size() > 0), 32'd1);
      code = (codeQ.size() > 0) ? codeQ.pop_front() : '0;
      rises    = 0;
      adc_miso = 1'($urandom);
      while (adc_csn == 1'b0) begin
        @(posedge adc_sclk or posedge adc_csn);
        if (adc_csn) break;
        rises++;
        @(negedge adc_sclk or posedge adc_csn);
        if (adc_csn) break;
        if (rises >= 3 && rises < FRAME_RISES) adc_miso = code[ADC_BITS - 1 - (rises - 3)];
        else                                   adc_miso = 1'($urandom);
      end
      if (!rst) checkOutput("sclk_rises_per_frame", 32'(rises), 32'(FRAME_RISES));
    end
  end

  // Monitor: strobe must occur exactly on the queued cycle and carry the
  // queued sample; overrun must track the model every cycle.
  always @(negedge clk) begin
    bit   expectStrobe;
    exp_t e;
    if (cyc > 0) begin
      checkOutput("overrun", 32'(overrun), 32'(mOvr));
      expectStrobe = (expQ.size() > 0) && (expQ[0].cyc == cyc);
      checkOutput("en_out", 32'(en_out), 32'(expectStrobe));
      if (en_out) strobeCount++;
      if (expectStrobe) begin
        e = expQ.pop_front();
        if (en_out) checkOutput("xout", 32'(xout), 32'(e.xout));
      end
    end
  end

  // Wait for a new chip-select falling edge within a cycle budget.
  task automatic waitCsnFall(input string name);
    int snap;
    int budget;
    snap   = csnFalls;
    budget = 3 * SAMPLE_PERIOD + LATENCY;
    while (csnFalls == snap && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput(name, 32'(csnFalls != snap), 32'd1);
  endtask

  initial begin
    int snapRise;
    int snapFall;
    int snapStrobe;
    int budget;

    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    checkOutput("reset_adc_csn", 32'(adc_csn), 32'd1);
    checkOutput("reset_adc_sclk", 32'(adc_sclk), 32'd0);
    checkOutput("reset_xout", 32'(xout), 32'd0);
    checkOutput("reset_en_out", 32'(en_out), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);

    // Disabled: no serial activity at all.
    applyStimulus(1'b0, 1'b0, 300);
    checkOutput("idle_sclk_rises", 32'(sclkRises), 32'd0);
    checkOutput("idle_csn_falls", 32'(csnFalls), 32'd0);

    // Boundary codes first, then random ones. With a 100-cycle period
    // every second tick falls inside a busy conversion.
    directedQ.push_back(12'hFFF);
    directedQ.push_back(12'h800);
    directedQ.push_back(12'h000);
    applyStimulus(1'b0, 1'b1, 2100);
    checkOutput("overrun_after_busy_tick", 32'(overrun), 32'd1);
    checkOutput("directed_codes_used", 32'(directedQ.size()), 32'd0);

    // Reset in the middle of the eighth SCLK period.
    waitCsnFall("csn_fall_before_reset");
    snapRise = sclkRises;
    budget   = 2 * LATENCY;
    while (sclkRises - snapRise < 8 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("reached_sclk_period_8", 32'(sclkRises - snapRise >= 8), 32'd1);
    snapStrobe = strobeCount;
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("abort_adc_csn", 32'(adc_csn), 32'd1);
    checkOutput("abort_adc_sclk", 32'(adc_sclk), 32'd0);
    checkOutput("abort_xout", 32'(xout), 32'd0);
    checkOutput("abort_overrun", 32'(overrun), 32'd0);
    applyStimulus(1'b0, 1'b1, LATENCY);
    checkOutput("abort_no_strobe", 32'(strobeCount - snapStrobe), 32'd0);
    applyStimulus(1'b0, 1'b1, 600);

    // Drop enable just after a conversion starts: it still completes.
    waitCsnFall("csn_fall_before_disable");
    snapStrobe = strobeCount;
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, LATENCY + 10);
    checkOutput("disable_single_strobe", 32'(strobeCount - snapStrobe), 32'd1);
    snapFall = csnFalls;
    snapRise = sclkRises;
    applyStimulus(1'b0, 1'b0, 1000);
    checkOutput("disable_no_csn", 32'(csnFalls - snapFall), 32'd0);
    checkOutput("disable_no_sclk", 32'(sclkRises - snapRise), 32'd0);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
